uart_rx_mv: RTL

- Parametrised UART receiver: serial line in, one word per frame out on a valid/ready stream. Next generation of the existing uart_rx.
- Adds over uart_rx:
  - generic data width
  - 2-flop input synchroniser
  - 3-sample majority vote per bit
  - false-start rejection
  - 1 or 2 stop bits
  - per-word parity and framing error flags
  - output holding register with backpressure and overrun reporting
- Sits between the pad-side serial input and the consumer logic.

---
 rtl/uart_rx_mv_if.sv | 39 +++
 rtl/uart_rx_mv.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mv_if.sv
// uart_rx_mv_if: output stream of the UART receiver.
//
// One received word per transfer, with its parity/framing flags.
// Handshake: the producer raises m_valid with m_data/m_parity_err/m_frame_err
// stable. It holds all of them until a cycle where m_valid & m_ready are both
// high at the rising clk edge. That edge is the transfer. m_ready may be
// driven freely and does not depend on m_valid.
//
// Signals:
//   m_data        received word (DATA_WIDTH bits, first received bit in bit 0)
//   m_parity_err  parity mismatch for m_data
//   m_frame_err   a stop bit of m_data's frame was sampled 0
//   m_valid       m_data and flags are valid
//   m_ready       consumer accepts the word
interface uart_rx_mv_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_parity_err;
    logic                  m_frame_err;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_parity_err,
        output m_frame_err,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_parity_err,
        input  m_frame_err,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_mv.sv
// uart_rx_mv: parametrised UART receiver with majority-vote sampling.
//
// The serial input passes through a 2-flop synchroniser; everything else
// works on the synchronised line rx. Each bit lasts P = prescale clk cycles,
// with P latched when the start bit begins. Within a bit, rx is sampled at
// cnt = H-1, H and H+1 (H = P>>1). The bit value is the majority of those
// three samples, decided at cnt = H+1. A start bit whose majority is 1 is
// treated as noise and dropped. Frames carry DATA_WIDTH data bits (LSB first),
// an optional parity bit and one or two stop bits. A finished word goes into
// a one-entry holding register. If that register is still full and is not
// being emptied, the new word is dropped and overrun pulses.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   s_data        serial line (idle high)
//   parity_en     a parity bit follows the data bits
//   parity_type   0 = even, 1 = odd
//   stop2         check two stop bits
//   prescale      clk cycles per bit (>= 4, else start edges are ignored)
//   m             output stream (master side of uart_rx_mv_if)
//   overrun       one-cycle pulse: a completed frame was dropped
//   busy          receiver FSM is not idle
//   dbg_state_o   current FSM state encoding, for observation only
//
// DATA_WIDTH is meant to be 5..9.
module uart_rx_mv #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_data,
    input  logic                      parity_en,
    input  logic                      parity_type,
    input  logic                      stop2,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    uart_rx_mv_if.master              m,
    output logic                      overrun,
    output logic                      busy,
    output logic [2:0]                dbg_state_o
);

    localparam int IDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    // Synchroniser.
    logic rx_meta_q;
    logic rx_q;
    logic rx;

    // Receiver state.
    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] p_q, p_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic                      smp0_q, smp0_d;
    logic                      smp1_q, smp1_d;
    logic                      perr_q, perr_d;
    logic                      ferr_q, ferr_d;

    // Holding register and status.
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      par_out_q, par_out_d;
    logic                      frm_out_q, frm_out_d;
    logic                      valid_q, valid_d;
    logic                      ovr_q, ovr_d;

    // Bit-timing decode.
    logic [PRESCALE_WIDTH-1:0] half;
    logic                      at_s0;
    logic                      at_s1;
    logic                      at_dec;
    logic                      at_last;
    logic                      maj;
    logic                      exp_par;
    logic                      complete;
    logic                      accept;

    assign rx = rx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_q      <= 1'b1;
        end else begin
            rx_meta_q <= s_data;
            rx_q      <= rx_meta_q;
        end
    end

    assign half    = p_q >> 1;
    assign at_s0   = (cnt_q == half - 1'b1);
    assign at_s1   = (cnt_q == half);
    assign at_dec  = (cnt_q == half + 1'b1);
    assign at_last = (cnt_q == p_q - 1'b1);

    // The third sample is rx itself in the decision cycle.
    assign maj     = (smp0_q & smp1_q) | (smp0_q & rx) | (smp1_q & rx);

    // Odd parity expects the complement of the data XOR.
    assign exp_par = (^shift_q) ^ parity_type;

    assign accept  = valid_q & m.m_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        smp0_d    = smp0_q;
        smp1_d    = smp1_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        data_d    = data_q;
        par_out_d = par_out_q;
        frm_out_d = frm_out_q;
        valid_d   = valid_q;
        ovr_d     = 1'b0;
        complete  = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
            if (at_s0) smp0_d = rx;
            if (at_s1) smp1_d = rx;
        end

        unique case (state_q)
            S_IDLE: begin
                // The cycle that sees the falling edge is cnt = 0 of the
                // start bit, so the counter resumes at 1.
                if (!rx && (prescale >= PRESCALE_WIDTH'(4))) begin
                    state_d   = S_START;
                    p_d       = prescale;
                    cnt_d     = PRESCALE_WIDTH'(1);
                    bit_idx_d = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                end
            end

            S_START: begin
                if (at_dec && maj) begin
                    // The line went back high: treat it as noise.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (at_last) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (at_dec) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
                if (at_last) begin
                    if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        bit_idx_d = '0;
                        state_d   = parity_en ? S_PARITY : S_STOP1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

            S_PARITY: begin
                if (at_dec && (maj != exp_par)) perr_d = 1'b1;
                if (at_last) state_d = S_STOP1;
            end

            S_STOP1: begin
                if (at_dec && !maj) ferr_d = 1'b1;
                if (stop2) begin
                    if (at_last) state_d = S_STOP2;
                end else if (at_dec) begin
                    // Finishing mid-stop-bit leaves the rest of the bit to
                    // catch the next start edge early.
                    complete = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end
            end

            S_STOP2: begin
                if (at_dec) begin
                    if (!maj) ferr_d = 1'b1;
                    complete = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A full register may take a new word only if it is emptied in the
        // same cycle; otherwise the new word is lost.
        if (complete) begin
            if (!valid_q || accept) begin
                data_d    = shift_q;
                par_out_d = perr_q;
                frm_out_d = ferr_d;
                valid_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            p_q       <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            smp0_q    <= 1'b1;
            smp1_q    <= 1'b1;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            data_q    <= '0;
            par_out_q <= 1'b0;
            frm_out_q <= 1'b0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            smp0_q    <= smp0_d;
            smp1_q    <= smp1_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            data_q    <= data_d;
            par_out_q <= par_out_d;
            frm_out_q <= frm_out_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign m.m_data       = data_q;
    assign m.m_parity_err = par_out_q;
    assign m.m_frame_err  = frm_out_q;
    assign m.m_valid      = valid_q;
    assign overrun        = ovr_q;
    assign busy           = (state_q != S_IDLE);
    assign dbg_state_o    = state_q;

endmodule
